accel_task_loader: RTL and testbench

//  Upstream feeder of the accelerator top. Accepts a valid/ready stream of initial

---
 rtl/accel_task_loader.sv | 180 ++++++++++++++++++
 tb/tb_accel_task_loader.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_task_loader.sv
// Streams initial entries into the InexRecur/state regfiles, then runs the accelerator until done.
// Optional ACC_LOADER_CLEAR_EN: zero-fill the unused tail of both regfiles before the run.
module accel_task_loader #(
    parameter int DEPTH = 4096,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_req,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [31:0]   s_inexrecur,
    input  logic [17:0]   s_state,
    input  logic          s_last,
    input  logic          acc_done,
    output logic          ran_we_InexRecur,
    output logic [AW-1:0] ran_w_addr_InexRecur,
    output logic [31:0]   ran_w_data_InexRecur,
    output logic          ran_we_state_external,
    output logic [AW-1:0] ran_w_addr_state_external,
    output logic [17:0]   ran_w_data_state_external,
    output logic          is_start,
    output logic          busy,
    output logic [AW:0]   entry_cnt,
    output logic          load_done,
    output logic          err_overflow
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    state_t        state;
    state_t        state_nxt;
    logic          fin;
    logic [AW:0]   cnt;
    logic          ovf_r;
    logic          we_r;
    logic [AW-1:0] addr_r;
    logic [31:0]   ir_r;
    logic [17:0]   st_r;
    logic          is_start_r;
    logic          full;
    logic          ready_c;
    logic          accept;
    logic          overflow_hit;
`ifdef ACC_LOADER_CLEAR_EN
    logic [AW:0]   clr_addr;
    logic          clr_active;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        full         = (cnt == FULL_CNT);
        ready_c      = (state == S_LOAD) && !fin && !full;
        accept       = s_valid && ready_c;
        overflow_hit = (state == S_LOAD) && !fin && full && s_valid;
        case (state)
            S_IDLE: begin
                if (load_req) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                // fin is registered, so the final beat's write has already been presented
                if (fin) begin
`ifdef ACC_LOADER_CLEAR_EN
                    state_nxt = full ? S_RUN : S_CLEAR;
`else
                    state_nxt = S_RUN;
`endif
                end
            end
            S_CLEAR: begin
`ifdef ACC_LOADER_CLEAR_EN
                if (clr_addr == FULL_CNT) begin
                    state_nxt = S_RUN;
                end
`else
                state_nxt = S_RUN;
`endif
            end
            S_RUN: begin
                if (acc_done) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef ACC_LOADER_CLEAR_EN
    always_comb begin
        clr_active = (state == S_CLEAR) && (clr_addr != FULL_CNT);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fin        <= 1'b0;
            cnt        <= '0;
            ovf_r      <= 1'b0;
            we_r       <= 1'b0;
            addr_r     <= '0;
            ir_r       <= '0;
            st_r       <= '0;
            is_start_r <= 1'b0;
`ifdef ACC_LOADER_CLEAR_EN
            clr_addr   <= '0;
`endif
        end else begin
            we_r       <= 1'b0;
            is_start_r <= (state == S_RUN) && (state_nxt == S_RUN);
            if ((state == S_IDLE) && load_req) begin
                cnt   <= '0;
                ovf_r <= 1'b0;
                fin   <= 1'b0;
            end
            if (accept) begin
                we_r   <= 1'b1;
                addr_r <= cnt[AW-1:0];
                ir_r   <= s_inexrecur;
                st_r   <= s_state;
                cnt    <= cnt + (AW+1)'(1);
                if (s_last) begin
                    fin <= 1'b1;
                end
            end
            if (overflow_hit) begin
                ovf_r <= 1'b1;
                fin   <= 1'b1;
            end
`ifdef ACC_LOADER_CLEAR_EN
            if ((state == S_LOAD) && (state_nxt == S_CLEAR)) begin
                clr_addr <= cnt;
            end
            if (clr_active) begin
                we_r     <= 1'b1;
                addr_r   <= clr_addr[AW-1:0];
                ir_r     <= '0;
                st_r     <= '0;
                clr_addr <= clr_addr + (AW+1)'(1);
            end
`endif
        end
    end

    assign s_ready                   = ready_c;
    assign ran_we_InexRecur          = we_r;
    assign ran_w_addr_InexRecur      = addr_r;
    assign ran_w_data_InexRecur      = ir_r;
    assign ran_we_state_external     = we_r;
    assign ran_w_addr_state_external = addr_r;
    assign ran_w_data_state_external = st_r;
    assign is_start                  = is_start_r;
    assign busy                      = (state != S_IDLE);
    assign entry_cnt                 = cnt;
    assign load_done                 = (state == S_DONE);
    assign err_overflow              = ovf_r;

endmodule

// File: tb/tb_accel_task_loader.sv
// Randomized bench for accel_task_loader with a transaction-level model of loads, writes and runs.
module tb_accel_task_loader;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    localparam int PH_IDLE = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_WAIT = 2;
    localparam int PH_RUN  = 3;
    localparam int PH_DONE = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_req = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [31:0]   s_inexrecur = '0;
    logic [17:0]   s_state = '0;
    logic          s_last = 1'b0;
    logic          acc_done = 1'b0;
    logic          we_ir;
    logic [AW-1:0] addr_ir;
    logic [31:0]   data_ir;
    logic          we_st;
    logic [AW-1:0] addr_st;
    logic [17:0]   data_st;
    logic          is_start;
    logic          busy;
    logic [AW:0]   entry_cnt;
    logic          load_done;
    logic          err_overflow;

    accel_task_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .load_req                  (load_req),
        .s_valid                   (s_valid),
        .s_ready                   (s_ready),
        .s_inexrecur               (s_inexrecur),
        .s_state                   (s_state),
        .s_last                    (s_last),
        .acc_done                  (acc_done),
        .ran_we_InexRecur          (we_ir),
        .ran_w_addr_InexRecur      (addr_ir),
        .ran_w_data_InexRecur      (data_ir),
        .ran_we_state_external     (we_st),
        .ran_w_addr_state_external (addr_st),
        .ran_w_data_state_external (data_st),
        .is_start                  (is_start),
        .busy                      (busy),
        .entry_cnt                 (entry_cnt),
        .load_done                 (load_done),
        .err_overflow              (err_overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: expected writes in order; due < 0 means an order-only (clear) write
    typedef struct {
        int          due;
        int          addr;
        logic [31:0] ir;
        logic [17:0] st;
    } wr_t;

    wr_t         wq[$];
    int          m_ph = PH_IDLE;
    int          m_cnt = 0;
    bit          m_ovf = 1'b0;
    int          m_wait = 0;
    int          m_ld_cycle = -10;
    int          n_writes = 0;
    logic [31:0] mem_ir[DEPTH];
    logic [17:0] mem_st[DEPTH];

    task automatic close_load();
`ifdef ACC_LOADER_CLEAR_EN
        for (int a = m_cnt; a < DEPTH; a++) wq.push_back('{-1, a, 32'h0, 18'h0});
`endif
        m_ph   = PH_WAIT;
        m_wait = 0;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_s_ready", 64'(s_ready), 0);
            chk("rst_we", 64'(we_ir | we_st), 0);
            chk("rst_is_start", 64'(is_start), 0);
            chk("rst_busy", 64'(busy), 0);
            chk("rst_entry_cnt", 64'(entry_cnt), 0);
            chk("rst_err_overflow", 64'(err_overflow), 0);
            chk("rst_load_done", 64'(load_done), 0);
            m_ph  = PH_IDLE;
            m_cnt = 0;
            m_ovf = 1'b0;
            wq.delete();
        end else begin
            if (m_ph == PH_DONE && cyc == m_ld_cycle + 1) m_ph = PH_IDLE;
            chk("s_ready", 64'(s_ready), 64'(m_ph == PH_LOAD && m_cnt < DEPTH));
            chk("entry_cnt", 64'(entry_cnt), 64'(m_cnt));
            chk("err_overflow", 64'(err_overflow), 64'(m_ovf));
            chk("we_match", 64'(we_st), 64'(we_ir));
            chk("addr_match", 64'(addr_st), 64'(addr_ir));
            chk("busy", 64'(busy), 64'(m_ph != PH_IDLE));
            chk("load_done", 64'(load_done), 64'(m_ph == PH_DONE && cyc == m_ld_cycle));
            if (is_start) chk("write_during_run", 64'(we_ir), 0);
            if (we_ir) begin
                n_writes++;
                mem_ir[addr_ir] = data_ir;
                mem_st[addr_ir] = data_st;
                if (wq.size() == 0) begin
                    chk("spurious_we", 64'(we_ir), 0);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    chk("w_addr", 64'(addr_ir), 64'(e.addr));
                    chk("w_data_ir", 64'(data_ir), 64'(e.ir));
                    chk("w_data_st", 64'(data_st), 64'(e.st));
                    if (e.due >= 0) chk("w_latency", 64'(cyc), 64'(e.due));
                end
            end else if (wq.size() > 0 && wq[0].due >= 0 && wq[0].due <= cyc) begin
                chk("missing_we", 64'(we_ir), 1);
                void'(wq.pop_front());
            end
            if (m_ph == PH_WAIT) begin
                if (is_start) begin
                    chk("writes_retired_before_start", 64'(wq.size()), 0);
                    m_ph = PH_RUN;
                end else begin
                    m_wait++;
                    if (m_wait > 30) begin
                        chk("run_start_timeout", 64'(is_start), 1);
                        m_ph = PH_RUN;
                    end
                end
            end
            if (m_ph == PH_IDLE || m_ph == PH_LOAD || m_ph == PH_DONE)
                chk("is_start_low", 64'(is_start), 0);
            if (m_ph == PH_RUN) chk("is_start_high", 64'(is_start), 1);
            case (m_ph)
                PH_IDLE: begin
                    if (load_req) begin
                        m_ph  = PH_LOAD;
                        m_cnt = 0;
                        m_ovf = 1'b0;
                    end
                end
                PH_LOAD: begin
                    if (s_valid) begin
                        if (m_cnt < DEPTH) begin
                            wq.push_back('{cyc + 1, m_cnt, s_inexrecur, s_state});
                            m_cnt++;
                            if (s_last) close_load();
                        end else begin
                            m_ovf = 1'b1;
                            close_load();
                        end
                    end
                end
                PH_RUN: begin
                    if (acc_done) begin
                        m_ph       = PH_DONE;
                        m_ld_cycle = cyc + 1;
                    end
                end
                default: ;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load_req();
        load_req = 1'b1;
        step();
        load_req = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] ir, input logic [17:0] st, input bit last,
                             output bit acc);
        s_valid     = 1'b1;
        s_inexrecur = ir;
        s_state     = st;
        s_last      = last;
        @(negedge clk);
        acc = s_ready;
        step();
        s_valid     = 1'b0;
        s_last      = 1'b0;
        s_inexrecur = $urandom;
        s_state     = 18'($urandom);
    endtask

    task automatic load_beats(input int n, input bit with_last, input bit noise, input bit rnd,
                              input logic [31:0] ir_base, input logic [17:0] st_base,
                              output int accepted);
        bit acc;
        accepted = 0;
        for (int i = 0; i < n; i++) begin
            if (noise) begin
                repeat ($urandom_range(0, 2)) begin
                    load_req = ($urandom_range(0, 2) == 0);
                    acc_done = ($urandom_range(0, 2) == 0);
                    step();
                    load_req = 1'b0;
                    acc_done = 1'b0;
                end
            end
            send_beat(rnd ? $urandom : ir_base + 32'(i),
                      rnd ? 18'($urandom) : st_base + 18'(i),
                      with_last && (i == n - 1), acc);
            if (!acc) break;
            accepted++;
        end
    endtask

    task automatic run_phase(input int ncyc, input bit noise);
        int waited = 0;
        while (!is_start && waited < 40) begin
            step();
            waited++;
        end
        chk("is_start_rise", 64'(is_start), 1);
        if (is_start) begin
            repeat (ncyc) begin
                if (noise) load_req = ($urandom_range(0, 3) == 0);
                step();
                load_req = 1'b0;
            end
            acc_done = 1'b1;
            step();
            acc_done = 1'b0;
        end
        repeat (3) step();
        chk("busy_after_run", 64'(busy), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        int n_acc;
        int w0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // three-beat load, then a 10-cycle run
        pulse_load_req();
        load_beats(3, 1, 0, 0, 32'hA, 18'h1, n_acc);
        run_phase(10, 0);
        chk("t2_entry_cnt", 64'(entry_cnt), 3);
        chk("t2_mem_ir0", 64'(mem_ir[0]), 64'h0A);
        chk("t2_mem_ir2", 64'(mem_ir[2]), 64'h0C);
        chk("t2_mem_st1", 64'(mem_st[1]), 64'h2);
        chk("t3_load_done_low", 64'(load_done), 0);

        // nine beats without last into an 8-entry file
        pulse_load_req();
        w0 = n_writes;
        load_beats(DEPTH + 1, 0, 0, 0, 32'h100, 18'h10, n_acc);
        chk("t4_accepted", 64'(n_acc), 8);
        chk("t4_err_overflow", 64'(err_overflow), 1);
        chk("t4_entry_cnt", 64'(entry_cnt), 8);
        chk("t4_writes", 64'(n_writes - w0), 8);
        run_phase(4, 0);
        chk("t4_err_sticky", 64'(err_overflow), 1);
        pulse_load_req();
        chk("t4_err_cleared", 64'(err_overflow), 0);

        // five beats with gaps and ignored load_req/acc_done noise
        load_beats(5, 1, 1, 0, 32'h200, 18'h20, n_acc);
        run_phase(6, 1);
        chk("t5_entry_cnt", 64'(entry_cnt), 5);
        chk("t5_mem_ir4", 64'(mem_ir[4]), 64'h204);
`ifdef ACC_LOADER_CLEAR_EN
        chk("t6_mem_ir5", 64'(mem_ir[5]), 0);
        chk("t6_mem_ir7", 64'(mem_ir[7]), 0);
        chk("t6_mem_st6", 64'(mem_st[6]), 0);
`else
        chk("t6_mem_ir5", 64'(mem_ir[5]), 64'h105);
        chk("t6_mem_st7", 64'(mem_st[7]), 64'h17);
`endif

        // exactly DEPTH beats with last on the final one: no overflow
        pulse_load_req();
        load_beats(DEPTH, 1, 0, 0, 32'h400, 18'h40, n_acc);
        run_phase(2, 0);
        chk("full_last_err", 64'(err_overflow), 0);
        chk("full_last_cnt", 64'(entry_cnt), 8);

        for (int r = 0; r < 10; r++) begin
            pulse_load_req();
            if ($urandom_range(0, 2) == 0)
                load_beats(DEPTH + 3, 0, 1, 1, 32'h0, 18'h0, n_acc);
            else
                load_beats($urandom_range(1, DEPTH), 1, 1, 1, 32'h0, 18'h0, n_acc);
            run_phase($urandom_range(1, 12), 1);
        end

        // asynchronous reset in the middle of a load
        pulse_load_req();
        load_beats(2, 0, 0, 0, 32'h300, 18'h30, n_acc);
        s_valid     = 1'b1;
        s_inexrecur = 32'h333;
        #2 rst_n = 1'b0;
        #1;
        chk("t1_we", 64'(we_ir), 0);
        chk("t1_s_ready", 64'(s_ready), 0);
        chk("t1_busy", 64'(busy), 0);
        chk("t1_entry_cnt", 64'(entry_cnt), 0);
        chk("t1_is_start", 64'(is_start), 0);
        s_valid = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();

        pulse_load_req();
        load_beats(4, 1, 1, 1, 32'h0, 18'h0, n_acc);
        run_phase(3, 0);
        chk("post_reset_cnt", 64'(entry_cnt), 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
